// File: rtl/ol_duty_cap.sv
// ol_duty_cap: measures an incoming PWM waveform and recovers the 8-bit duty
// code round(ton*255/period) from the measured high time and period.
// Optional deglitch filter after the synchronizer: define OL_DUTY_CAP_DEGLITCH_EN
// (this also adds the DEGLITCH_LEN parameter).
module ol_duty_cap #(
    parameter int CNT_W       = 11,
    parameter int SYNC_STAGES = 2
`ifdef OL_DUTY_CAP_DEGLITCH_EN
    ,
    parameter int DEGLITCH_LEN = 3
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pwm,
    output logic [7:0] o_duty,
    output logic       o_valid,
    output logic       o_stuck,
    output logic       o_ovr
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int NUM_W  = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {IDLE = 1'b0, MEAS = 1'b1} meas_state_t;
    typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_DONE = 2'd2} div_state_t;

    logic [SYNC_N-1:0] sync_r;
    logic              s_pwm_s;
    logic              lvl_s;
    logic              lvl_d_r;
    logic              rise_r;
    meas_state_t       meas_r, meas_next_s;
    div_state_t        div_r, div_next_s;
    logic [CNT_W-1:0]  p_cnt_r, h_cnt_r;
    logic              latch_s, ovr_s, timeout_s, done_s;
    logic [NUM_W-1:0]  num_s;
    logic [CNT_W-1:0]  rem_r, den_r, rem_next_s;
    logic [7:0]        num_lo_r;
    logic [6:0]        quo_r;
    logic [2:0]        bit_cnt_r;
    logic [CNT_W:0]    trial_s;
    logic              fits_s;
    logic [7:0]        quo_final_s;
    logic [7:0]        duty_r;
    logic              valid_r, stuck_r, ovr_r;

    // Synchronizer chain bringing the asynchronous PWM into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_N-2:0], i_pwm};
        end
    end

    assign s_pwm_s = sync_r[SYNC_N-1];

`ifdef OL_DUTY_CAP_DEGLITCH_EN
    localparam int DG_N = (DEGLITCH_LEN < 1) ? 1 : DEGLITCH_LEN;
    localparam int DG_W = $clog2(DG_N + 1);
    localparam logic [DG_W-1:0] DG_LAST = DG_W'(DG_N - 1);

    logic            filt_r;
    logic [DG_W-1:0] dg_cnt_r;

    // Deglitch filter: the level follows only after DG_N consecutive new samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filt_r   <= 1'b0;
            dg_cnt_r <= '0;
        end else if (s_pwm_s == filt_r) begin
            dg_cnt_r <= '0;
        end else if (dg_cnt_r == DG_LAST) begin
            filt_r   <= s_pwm_s;
            dg_cnt_r <= '0;
        end else begin
            dg_cnt_r <= dg_cnt_r + DG_W'(1);
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = s_pwm_s;
`endif

    // Registered rising-edge detector on the conditioned level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lvl_d_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            lvl_d_r <= lvl_s;
            rise_r  <= lvl_s & ~lvl_d_r;
        end
    end

    // FSM state registers for the measurement and divider machines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meas_r <= IDLE;
            div_r  <= DIV_IDLE;
        end else begin
            meas_r <= meas_next_s;
            div_r  <= div_next_s;
        end
    end

    // Measurement FSM: a rise either hands H/P to the divider or flags overrun;
    // a full period counter without a rise is a timeout (rise has priority).
    always_comb begin
        meas_next_s = meas_r;
        latch_s     = 1'b0;
        ovr_s       = 1'b0;
        timeout_s   = 1'b0;
        case (meas_r)
            IDLE: begin
                if (rise_r) begin
                    meas_next_s = MEAS;
                end else begin
                    meas_next_s = IDLE;
                end
            end
            MEAS: begin
                if (rise_r) begin
                    if (div_r == DIV_RUN) begin
                        ovr_s = 1'b1;
                    end else begin
                        latch_s = 1'b1;
                    end
                    meas_next_s = MEAS;
                end else if (p_cnt_r == CNT_MAX) begin
                    timeout_s   = 1'b1;
                    meas_next_s = IDLE;
                end else begin
                    meas_next_s = MEAS;
                end
            end
            default: meas_next_s = IDLE;
        endcase
    end

    // Divider FSM: eight RUN cycles, result written on the last one so the
    // DONE cycle coincides with o_valid.
    always_comb begin
        div_next_s = div_r;
        done_s     = 1'b0;
        case (div_r)
            DIV_IDLE: begin
                if (latch_s) begin
                    div_next_s = DIV_RUN;
                end else begin
                    div_next_s = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                if (bit_cnt_r == 3'd7) begin
                    div_next_s = DIV_DONE;
                    done_s     = 1'b1;
                end else begin
                    div_next_s = DIV_RUN;
                end
            end
            DIV_DONE: begin
                if (latch_s) begin
                    div_next_s = DIV_RUN;
                end else begin
                    div_next_s = DIV_IDLE;
                end
            end
            default: div_next_s = DIV_IDLE;
        endcase
    end

    // Numerator H*255 + P/2 and one restoring shift-subtract step.
    always_comb begin
        num_s       = ({h_cnt_r, 8'd0} - {8'd0, h_cnt_r}) + {9'd0, p_cnt_r[CNT_W-1:1]};
        trial_s     = {rem_r, num_lo_r[7]};
        fits_s      = (trial_s >= {1'b0, den_r});
        if (fits_s) begin
            rem_next_s = CNT_W'(trial_s - {1'b0, den_r});
        end else begin
            rem_next_s = CNT_W'(trial_s);
        end
        quo_final_s = {quo_r, fits_s};
    end

    // Period/high-time counters; the rise cycle itself counts as 1 for both.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p_cnt_r <= '0;
            h_cnt_r <= '0;
        end else begin
            case (meas_r)
                IDLE: begin
                    if (rise_r) begin
                        p_cnt_r <= CNT_ONE;
                        h_cnt_r <= CNT_ONE;
                    end else begin
                        p_cnt_r <= '0;
                        h_cnt_r <= '0;
                    end
                end
                MEAS: begin
                    if (rise_r) begin
                        p_cnt_r <= CNT_ONE;
                        h_cnt_r <= CNT_ONE;
                    end else if (p_cnt_r != CNT_MAX) begin
                        p_cnt_r <= p_cnt_r + CNT_ONE;
                        h_cnt_r <= h_cnt_r + {{(CNT_W-1){1'b0}}, lvl_s};
                    end
                end
                default: begin
                    p_cnt_r <= '0;
                    h_cnt_r <= '0;
                end
            endcase
        end
    end

    // Divider datapath: load on latch, shift one quotient bit per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem_r     <= '0;
            den_r     <= '0;
            num_lo_r  <= 8'd0;
            quo_r     <= 7'd0;
            bit_cnt_r <= 3'd0;
        end else if (latch_s) begin
            rem_r     <= num_s[NUM_W-1:8];
            num_lo_r  <= num_s[7:0];
            den_r     <= p_cnt_r;
            quo_r     <= 7'd0;
            bit_cnt_r <= 3'd0;
        end else if (div_r == DIV_RUN) begin
            rem_r     <= rem_next_s;
            num_lo_r  <= {num_lo_r[6:0], 1'b0};
            quo_r     <= {quo_r[5:0], fits_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

    // Output registers; a timeout overrides a same-cycle division result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            duty_r  <= 8'd0;
            valid_r <= 1'b0;
            stuck_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            ovr_r   <= ovr_s;
            if (timeout_s) begin
                duty_r  <= lvl_s ? 8'd255 : 8'd0;
                valid_r <= 1'b1;
            end else if (done_s) begin
                duty_r  <= (den_r == '0) ? 8'd0 : quo_final_s;
                valid_r <= 1'b1;
            end
            if (rise_r) begin
                stuck_r <= 1'b0;
            end else if (timeout_s) begin
                stuck_r <= 1'b1;
            end
        end
    end

    assign o_duty  = duty_r;
    assign o_valid = valid_r;
    assign o_stuck = stuck_r;
    assign o_ovr   = ovr_r;

endmodule
